// File: rtl/sysid_checker.sv
// Avalon-MM read master: fetches system-ID word 0 (ID) and word 1 (timestamp), compares both
// against build-time constants. Define SYSID_CHECKER_AUTOSTART_EN to launch one check after reset.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd29,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1718298719,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  input  logic        readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // state   | meaning
  // IDLE    | waiting for start
  // RD_ID   | read command for word 0 outstanding
  // WAIT_ID | word 0 accepted, waiting for data
  // RD_TS   | read command for word 1 outstanding
  // WAIT_TS | word 1 accepted, waiting for data
  // DONE    | results held until next start
  typedef enum logic [2:0] {IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE} state_t;

  localparam logic [15:0] TMR_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] tmr;
  logic        start_req;

`ifdef SYSID_CHECKER_AUTOSTART_EN
  logic auto_pend;

  always_ff @(posedge clock) begin
    if (reset) auto_pend <= 1'b1;
    else       auto_pend <= 1'b0;
  end

  assign start_req = start | auto_pend;
`else
  assign start_req = start;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      tmr      <= '0;
      address  <= 1'b0;
      read     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_req) begin
            done     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
            read     <= 1'b1;
            address  <= 1'b0;
            busy     <= 1'b1;
            tmr      <= '0;
            state    <= RD_ID;
          end
        end
        RD_ID, WAIT_ID, RD_TS, WAIT_TS: begin
          // Expiry takes priority over any handshake landing on the same edge.
          if (tmr == TMR_LAST) begin
            read    <= 1'b0;
            address <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            if (state == RD_ID || state == WAIT_ID) id_ok <= 1'b0;
            else                                    ts_ok <= 1'b0;
            state   <= DONE;
          end else begin
            tmr <= tmr + 16'd1;
            case (state)
              RD_ID, RD_TS: begin
                if (!waitrequest) begin
                  read  <= 1'b0;
                  state <= (state == RD_ID) ? WAIT_ID : WAIT_TS;
                end
              end
              WAIT_ID: begin
                if (readdatavalid) begin
                  id_value <= readdata;
                  id_ok    <= (readdata == EXPECTED_ID);
                  read     <= 1'b1;
                  address  <= 1'b1;
                  tmr      <= '0;
                  state    <= RD_TS;
                end
              end
              default: begin
                if (readdatavalid) begin
                  ts_value <= readdata;
                  ts_ok    <= (readdata == EXPECTED_TIMESTAMP);
                  address  <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
                end
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM read master that interrogates a system-ID peripheral and checks its contents. On start, it reads the ID word at address 0 and the timestamp word at address 1, then compares both against build-time expected values. It reports pass/fail, the captured words and any bus timeout. It sits beside the Nios II on the same fabric and drives a board LED or status register, so a mismatched bitstream/software pairing is caught in hardware.

## Interface
- EXPECTED_ID, default 29: expected value of word 0.
- EXPECTED_TIMESTAMP, default 1718298719: expected value of word 1.
- TIMEOUT_CYCLES, default 255: per-transaction cycle limit, range 1..65535.
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to run a check.
- address  out  1  master word address (0 = ID, 1 = timestamp).
- read  out  1  Avalon read request.
- readdata  in  32  read data from the slave.
- waitrequest  in  1  slave stall; the command is accepted on an edge where read=1 and waitrequest=0.
- readdatavalid  in  1  readdata is valid this cycle.
- busy  out  1  a check is in progress.
- done  out  1  the check has finished; held until the next start or reset.
- id_ok  out  1  captured ID equals EXPECTED_ID.
- ts_ok  out  1  captured timestamp equals EXPECTED_TIMESTAMP.
- timeout  out  1  the check was aborted by the timeout.
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.

## Operation
- States: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE.
- IDLE or DONE with start=1: clear done, id_ok, ts_ok, timeout, id_value and ts_value, then go to RD_ID.
- RD_ID: read=1, address=0. On acceptance, go to WAIT_ID.
- WAIT_ID: read=0. When readdatavalid=1:
  - id_value <= readdata.
  - id_ok <= (readdata == EXPECTED_ID).
  - Go to RD_TS.
- RD_TS and WAIT_TS behave the same way with address=1, capturing into ts_value and ts_ok. On data, go to DONE with done=1.
- busy=1 in the four RD and WAIT states.
- start is ignored while busy.
- readdatavalid outside the WAIT states is ignored. So is readdatavalid in the same cycle as acceptance, because the minimum read latency is 1.
- Timeout: a 16-bit counter clears on entry to each RD state and increments every cycle in the RD and WAIT states. When it reaches TIMEOUT_CYCLES:
  - read drops to 0.
  - timeout=1 and done=1.
  - The ok flag of the pending word is forced to 0 and the other ok flag keeps its current value.
  - Go to DONE.
- Comparison is a full 32-bit equality with no masking.
- address is held at 0 outside RD_TS and WAIT_TS.

## Timing
- Reset drives state to IDLE and every output to 0, including address, read, all flags, id_value and ts_value.
- Reset asserted mid-transaction aborts it on that edge. Any later readdatavalid is ignored.
- Zero-wait, latency-1 slave, with start sampled at edge k:
  - read=1, address=0 from edge k to k+1.
  - Data at edge k+2.
  - read=1, address=1 from edge k+2 to k+3.
  - Data at edge k+4.
  - done=1 after edge k+4, so the minimum start-to-done latency is 4 cycles.
- Each waitrequest cycle adds 1 cycle. Each extra latency cycle adds 1 cycle.
- Outputs are registered, with no combinational path from inputs to outputs.
- Simultaneous start and timeout-expiry: the timeout wins, because start is ignored while busy.

## Configuration
- SYSID_CHECKER_AUTOSTART_EN:
  - Defined: one internal start pulse is generated on the first edge after reset deasserts. The external start still works afterwards.
  - Undefined: only the start port launches a check, and the block stays in IDLE after reset.

## Test plan
- Slave returns 29 and 1718298719 with zero wait and latency 1, start pulsed -> done at +4 edges, id_ok=1, ts_ok=1, timeout=0, and id_value/ts_value equal the returned words.
- Slave returns 30 for word 0 -> id_ok=0, ts_ok=1, id_value=30.
- waitrequest held for 3 cycles on each read and latency 2 -> done at +12 edges, both ok flags 1, read stays asserted through every stall.
- TIMEOUT_CYCLES=8 and readdatavalid never arrives for word 1 -> after 8 cycles in RD_TS/WAIT_TS: timeout=1, done=1, ts_ok=0, id_ok=1, read=0.
- start pulsed while busy, then a stray readdatavalid in IDLE -> no restart and no capture.
- Reset asserted in WAIT_ID -> all outputs 0 next edge.
- With SYSID_CHECKER_AUTOSTART_EN defined -> check runs after reset with no start pulse.
